neuron_layer_sequencer: RTL and testbench

Time-multiplexes one combinational LIF neuron core across N_NEURONS neurons of a layer. Holds per-neuron membrane state, previous-spike flags and weight vectors. Each accepted input spike vector triggers one timestep: it drives the core once per neuron, writes the results back and emits the layer's spike vector. It sits directly upstream of the neuron core and also consumes the core's outputs.

---
 rtl/neuron_layer_sequencer.sv | 122 ++++++++++++
 tb/tb_neuron_layer_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_layer_sequencer.sv
// Time-multiplexes one combinational LIF core over a layer of neurons,
// holding per-neuron membrane, spike flag and weight state.
module neuron_layer_sequencer #(
    parameter int N_NEURONS   = 4,
    parameter int N_STAGE     = 3,
    parameter int N_MEMBRANE  = N_STAGE + 2,
    parameter int N_THRESHOLD = N_MEMBRANE - 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_we,
    input  logic [$clog2(N_NEURONS)-1:0]  cfg_addr,
    input  logic [(2**N_STAGE)-1:0]       cfg_weights,
    input  logic                          param_we,
    input  logic [N_THRESHOLD-1:0]        param_threshold,
    input  logic [2:0]                    param_shift,
    input  logic                          clear_state,
    input  logic                          in_valid,
    input  logic [(2**N_STAGE)-1:0]       in_inputs,
    output logic                          in_ready,
    output logic [(2**N_STAGE)-1:0]       core_inputs,
    output logic [(2**N_STAGE)-1:0]       core_weights,
    output logic [2:0]                    core_shift,
    output logic [N_THRESHOLD-1:0]        core_threshold,
    output logic signed [N_MEMBRANE-1:0]  core_last_membrane,
    output logic                          core_was_spike,
    input  logic signed [N_MEMBRANE-1:0]  core_new_membrane,
    input  logic                          core_is_spike,
    output logic                          out_valid,
    output logic [N_NEURONS-1:0]          out_spikes
);

    localparam int N_SYN = 2 ** N_STAGE;
    localparam int IDXW  = $clog2(N_NEURONS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_NEURONS - 1);
    localparam logic [N_THRESHOLD-1:0] THR_RST =
        {1'b1, {(N_THRESHOLD-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_e;

    state_e                       state_q;
    logic [IDXW-1:0]              idx_q;
    logic [N_SYN-1:0]             in_q;
    logic signed [N_MEMBRANE-1:0] mem_q [N_NEURONS];
    logic [N_SYN-1:0]             w_q   [N_NEURONS];
    logic [N_NEURONS-1:0]         spk_q;
    logic [N_NEURONS-1:0]         shadow_q;
    logic [N_NEURONS-1:0]         shadow_d;
    logic [N_THRESHOLD-1:0]       thr_q;
    logic [2:0]                   shift_q;
    logic [N_NEURONS-1:0]         out_spikes_q;
    logic                         out_valid_q;

    // Shadow including the bit being written this cycle, so the
    // final neuron's spike lands in out_spikes on the closing edge.
    always_comb begin
        shadow_d = shadow_q;
        shadow_d[idx_q] = core_is_spike;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            in_q         <= '0;
            spk_q        <= '0;
            shadow_q     <= '0;
            thr_q        <= THR_RST;
            shift_q      <= '0;
            out_spikes_q <= '0;
            out_valid_q  <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_q[i] <= '0;
                w_q[i]   <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cfg_we) w_q[cfg_addr] <= cfg_weights;
                    if (param_we) begin
                        thr_q   <= param_threshold;
                        shift_q <= param_shift;
                    end
                    if (clear_state) begin
                        spk_q <= '0;
                        for (int i = 0; i < N_NEURONS; i++)
                            mem_q[i] <= '0;
                    end
                    if (in_valid) begin
                        in_q    <= in_inputs;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    mem_q[idx_q] <= core_new_membrane;
                    spk_q[idx_q] <= core_is_spike;
                    shadow_q     <= shadow_d;
                    idx_q        <= idx_q + IDXW'(1);
                    if (idx_q == LAST_IDX) begin
                        state_q      <= IDLE;
                        out_spikes_q <= shadow_d;
                        out_valid_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready           = (state_q == IDLE);
    assign core_inputs        = (state_q == RUN) ? in_q : '0;
    assign core_weights       = w_q[idx_q];
    assign core_last_membrane = mem_q[idx_q];
    assign core_was_spike     = spk_q[idx_q];
    assign core_threshold     = thr_q;
    assign core_shift         = shift_q;
    assign out_valid          = out_valid_q;
    assign out_spikes         = out_spikes_q;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Directed bench for neuron_layer_sequencer with a stub core that
// adds 3 to the membrane and spikes at one chosen neuron index.
module tb_neuron_layer_sequencer;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic [7:0]        cfg_weights;
    logic              param_we;
    logic [3:0]        param_threshold;
    logic [2:0]        param_shift;
    logic              clear_state;
    logic              in_valid;
    logic [7:0]        in_inputs;
    logic              in_ready;
    logic [7:0]        core_inputs;
    logic [7:0]        core_weights;
    logic [2:0]        core_shift;
    logic [3:0]        core_threshold;
    logic signed [4:0] core_last_membrane;
    logic              core_was_spike;
    logic signed [4:0] core_new_membrane;
    logic              core_is_spike;
    logic              out_valid;
    logic [3:0]        out_spikes;

    int checks   = 0;
    int failures = 0;

    logic              stub_spk;
    int                spike_at = 2;
    logic signed [4:0] exp_mem [4];
    logic              exp_spk [4];
    logic [7:0]        exp_w   [4];
    logic [3:0]        exp_thr;
    logic [2:0]        exp_shift;
    logic [3:0]        exp_out;
    logic [3:0]        prev_out;

    always #5 clk = ~clk;

    assign core_new_membrane = core_last_membrane + 5'sd3;
    assign core_is_spike     = stub_spk;

    neuron_layer_sequencer #(
        .N_NEURONS(4),
        .N_STAGE(3)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .cfg_we             (cfg_we),
        .cfg_addr           (cfg_addr),
        .cfg_weights        (cfg_weights),
        .param_we           (param_we),
        .param_threshold    (param_threshold),
        .param_shift        (param_shift),
        .clear_state        (clear_state),
        .in_valid           (in_valid),
        .in_inputs          (in_inputs),
        .in_ready           (in_ready),
        .core_inputs        (core_inputs),
        .core_weights       (core_weights),
        .core_shift         (core_shift),
        .core_threshold     (core_threshold),
        .core_last_membrane (core_last_membrane),
        .core_was_spike     (core_was_spike),
        .core_new_membrane  (core_new_membrane),
        .core_is_spike      (core_is_spike),
        .out_valid          (out_valid),
        .out_spikes         (out_spikes)
    );

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            exp_mem[i] = '0;
            exp_spk[i] = 1'b0;
            exp_w[i]   = '0;
        end
        exp_thr   = 4'd8;
        exp_shift = 3'd0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Starts at a negedge in IDLE, ends at the negedge of the out_valid cycle.
    task automatic run_timestep(input logic [7:0] vec, input logic clr,
                                input logic hold);
        in_valid    = 1'b1;
        in_inputs   = vec;
        clear_state = clr;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready: got %b expected 1", in_ready);
        end
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                exp_mem[i] = '0;
                exp_spk[i] = 1'b0;
            end
        end
        exp_out = '0;
        @(negedge clk);
        in_valid    = hold;
        clear_state = hold;
        cfg_we      = hold;
        cfg_addr    = 2'd0;
        cfg_weights = 8'hFF;
        in_inputs   = 8'h00;
        for (int k = 0; k < 4; k++) begin
            stub_spk = (k == spike_at);
            #1;
            checks++;
            if (core_inputs !== vec) begin
                failures++;
                $display("FAIL core_inputs[%0d]: got %h expected %h",
                         k, core_inputs, vec);
            end
            checks++;
            if (core_last_membrane !== exp_mem[k]) begin
                failures++;
                $display("FAIL last_membrane[%0d]: got %0d expected %0d",
                         k, core_last_membrane, exp_mem[k]);
            end
            checks++;
            if (core_was_spike !== exp_spk[k]) begin
                failures++;
                $display("FAIL was_spike[%0d]: got %b expected %b",
                         k, core_was_spike, exp_spk[k]);
            end
            checks++;
            if (core_weights !== exp_w[k]) begin
                failures++;
                $display("FAIL core_weights[%0d]: got %h expected %h",
                         k, core_weights, exp_w[k]);
            end
            checks++;
            if (core_threshold !== exp_thr || core_shift !== exp_shift) begin
                failures++;
                $display("FAIL thr_shift[%0d]: got %0d/%0d expected %0d/%0d",
                         k, core_threshold, core_shift, exp_thr, exp_shift);
            end
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL run_flags[%0d]: got rdy=%b ov=%b expected 0/0",
                         k, in_ready, out_valid);
            end
            exp_mem[k] = exp_mem[k] + 5'sd3;
            exp_spk[k] = (k == spike_at);
            exp_out[k] = (k == spike_at);
            @(negedge clk);
        end
        in_valid    = 1'b0;
        clear_state = 1'b0;
        cfg_we      = 1'b0;
        stub_spk    = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL done_flags: got ov=%b rdy=%b expected 1/1",
                     out_valid, in_ready);
        end
        checks++;
        if (out_spikes !== exp_out) begin
            failures++;
            $display("FAIL out_spikes: got %b expected %b", out_spikes, exp_out);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got rdy=%b ov=%b expected 1/0",
                     in_ready, out_valid);
        end
        checks++;
        if (core_threshold !== 4'd8 || core_last_membrane !== 5'sd0) begin
            failures++;
            $display("FAIL reset_core: got thr=%0d mem=%0d expected 8/0",
                     core_threshold, core_last_membrane);
        end
        checks++;
        if (core_inputs !== 8'h00 || out_spikes !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outs: got in=%h spk=%b expected 00/0000",
                     core_inputs, out_spikes);
        end
    endtask

    task automatic test_basic();
        spike_at = 2;
        run_timestep(8'h0F, 1'b0, 1'b0);
        checks++;
        if (out_spikes !== 4'b0100) begin
            failures++;
            $display("FAIL basic_spikes: got %b expected 0100", out_spikes);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL pulse_width: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        spike_at = 2;
        run_timestep(8'h81, 1'b0, 1'b0);
        run_timestep(8'h42, 1'b0, 1'b0);
        run_timestep(8'h18, 1'b0, 1'b0);
        spike_at = 1;
        run_timestep(8'hC3, 1'b0, 1'b0);
        prev_out = out_spikes;
        checks++;
        if (prev_out !== 4'b0010) begin
            failures++;
            $display("FAIL spike_at1: got %b expected 0010", prev_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || out_spikes !== 4'b0010) begin
                failures++;
                $display("FAIL hold_out: got ov=%b spk=%b expected 0/0010",
                         out_valid, out_spikes);
            end
        end
        spike_at = 2;
    endtask

    task automatic test_config();
        @(negedge clk);
        cfg_we          = 1'b1;
        cfg_addr        = 2'd3;
        cfg_weights     = 8'hA5;
        param_we        = 1'b1;
        param_threshold = 4'd5;
        param_shift     = 3'd2;
        @(negedge clk);
        cfg_addr    = 2'd1;
        cfg_weights = 8'h3C;
        param_we    = 1'b0;
        @(negedge clk);
        cfg_we    = 1'b0;
        exp_w[3]  = 8'hA5;
        exp_w[1]  = 8'h3C;
        exp_thr   = 4'd5;
        exp_shift = 3'd2;
        run_timestep(8'h5A, 1'b0, 1'b0);
    endtask

    task automatic test_run_drop();
        @(negedge clk);
        run_timestep(8'hF0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_accept: got ov=%b rdy=%b expected 0/1",
                     out_valid, in_ready);
        end
        run_timestep(8'h0F, 1'b0, 1'b0);
    endtask

    task automatic test_clear();
        @(negedge clk);
        clear_state = 1'b1;
        @(negedge clk);
        clear_state = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_mem[i] = '0;
            exp_spk[i] = 1'b0;
        end
        checks++;
        if (out_spikes !== 4'b0100 || core_weights !== 8'h00) begin
            failures++;
            $display("FAIL clear_keeps: got spk=%b w=%h expected 0100/00",
                     out_spikes, core_weights);
        end
        run_timestep(8'h33, 1'b0, 1'b0);
        @(negedge clk);
        run_timestep(8'h66, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        in_valid  = 1'b1;
        in_inputs = 8'hAA;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL abort_flags: got ov=%b rdy=%b expected 0/1",
                         out_valid, in_ready);
            end
            @(negedge clk);
        end
        checks++;
        if (out_spikes !== 4'b0000 || core_threshold !== 4'd8) begin
            failures++;
            $display("FAIL abort_state: got spk=%b thr=%0d expected 0000/8",
                     out_spikes, core_threshold);
        end
        run_timestep(8'h99, 1'b0, 1'b0);
    endtask

    initial begin
        reset           = 1'b1;
        cfg_we          = 1'b0;
        cfg_addr        = '0;
        cfg_weights     = '0;
        param_we        = 1'b0;
        param_threshold = '0;
        param_shift     = '0;
        clear_state     = 1'b0;
        in_valid        = 1'b0;
        in_inputs       = '0;
        stub_spk        = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_back_to_back();
        test_config();
        test_run_drop();
        test_clear();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
